horizontal_tf_gen: RTL and testbench

Parametrised run-time-configurable twiddle-factor sequence generator for the horizontal (in-stage) twiddle path of the radix-16 NTT pipeline.
- Emits tf_k = seed * step^k mod N_in, holding each value for group_len valid cycles, for num_groups groups.
- Replaces the fixed 4-cycle / 4-group recurrence with configurable group length, group count and multiplier latency.
- Adds stall, done and error signalling.
- Output feeds the data-path MulMod128 B operand.

---
 rtl/horizontal_tf_pkg.sv | 23 ++
 rtl/mulmod_pipe.sv | 56 +++++
 rtl/horizontal_tf_gen.sv | 141 ++++++++++++++
 tb/tb_horizontal_tf_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/horizontal_tf_pkg.sv
// Shared types, default parameters and helpers for the horizontal twiddle generator.
package horizontal_tf_pkg;

  localparam int unsigned DEF_P_WIDTH = 64;
  localparam int unsigned DEF_GL_W    = 4;
  localparam int unsigned DEF_NG_W    = 4;
  localparam int unsigned DEF_MUL_LAT = 3;

  // Goldilocks prime used by the NTT pipeline
  localparam logic [63:0] N_GOLD = 64'hFFFF_FFFF_0000_0001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A run is only legal if each group outlasts the multiplier latency
  function automatic logic cfg_legal(input int unsigned len, input int unsigned groups,
                                     input int unsigned lat);
    return (len >= lat) && (len != 0) && (groups != 0);
  endfunction

endpackage

// File: rtl/mulmod_pipe.sv
// Pipelined modular multiplier: s = (a * b) mod n after exactly MUL_LAT register stages.
module mulmod_pipe #(
  parameter int unsigned P_WIDTH = 64,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  input  logic [P_WIDTH-1:0] n,
  input  logic               in_valid,
  output logic [P_WIDTH-1:0] s,
  output logic               out_valid
);

  localparam int unsigned PROD_W = 2 * P_WIDTH;

  logic [PROD_W-1:0]               prod;
  logic [P_WIDTH-1:0]              red;
  logic [MUL_LAT-1:0][P_WIDTH-1:0] s_q;
  logic [MUL_LAT-1:0]              v_q;

  // Full-width product reduced into the first stage
  always_comb begin
    prod = PROD_W'(a) * PROD_W'(b);
    red  = P_WIDTH'(prod % PROD_W'(n));
  end

  if (MUL_LAT > 1) begin : g_deep
    // Data shift register, no reset needed since valids qualify it
    always_ff @(posedge clk) begin
      s_q <= {s_q[MUL_LAT-2:0], red};
    end

    // Valid shift register, cleared by reset
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) v_q <= '0;
      else       v_q <= {v_q[MUL_LAT-2:0], in_valid};
    end
  end else begin : g_one
    // Single data stage
    always_ff @(posedge clk) begin
      s_q <= red;
    end

    // Single valid stage, cleared by reset
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) v_q <= '0;
      else       v_q <= in_valid;
    end
  end

  assign s         = s_q[MUL_LAT-1];
  assign out_valid = v_q[MUL_LAT-1];

endmodule

// File: rtl/horizontal_tf_gen.sv
// Run-time-configurable twiddle sequence generator: tf_k = seed * step^k mod N,
// each value held for group_len advance cycles over num_groups groups.
module horizontal_tf_gen
  import horizontal_tf_pkg::*;
#(
  parameter int unsigned P_WIDTH = DEF_P_WIDTH,
  parameter int unsigned GL_W    = DEF_GL_W,
  parameter int unsigned NG_W    = DEF_NG_W,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               CEN,
  input  logic               start,
  input  logic [P_WIDTH-1:0] seed_in,
  input  logic [P_WIDTH-1:0] step_in,
  input  logic [P_WIDTH-1:0] N_in,
  input  logic [GL_W-1:0]    group_len,
  input  logic [NG_W-1:0]    num_groups,
  output logic [P_WIDTH-1:0] tf_out,
  output logic               tf_valid,
  output logic [NG_W-1:0]    group_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e             state;
  logic [P_WIDTH-1:0] cur;
  logic [P_WIDTH-1:0] nxt;
  logic [P_WIDTH-1:0] step_q;
  logic [GL_W-1:0]    len_q;
  logic [NG_W-1:0]    ng_q;
  logic [GL_W-1:0]    phase;

  logic               cfg_ok;
  logic               last_phase;
  logic               last_grp;
  logic               next_last;
  logic [P_WIDTH-1:0] fwd;
  logic [P_WIDTH-1:0] mul_a;
  logic [P_WIDTH-1:0] mul_b;
  logic               mul_in_v;
  logic [P_WIDTH-1:0] mul_s;
  logic               mul_ov;

  // Next value for a group is launched as soon as the current one is loaded,
  // so a result landing exactly on the boundary cycle is forwarded into cur.
  always_comb begin
    cfg_ok     = cfg_legal(32'(group_len), 32'(num_groups), MUL_LAT);
    last_phase = (phase == len_q - GL_W'(1));
    last_grp   = (group_idx == ng_q - NG_W'(1));
    next_last  = ((group_idx + NG_W'(1)) == (ng_q - NG_W'(1)));
    fwd        = mul_ov ? mul_s : nxt;
    mul_a      = fwd;
    mul_b      = step_q;
    mul_in_v   = 1'b0;
    if (state == IDLE) begin
      mul_a    = seed_in;
      mul_b    = step_in;
      mul_in_v = start && cfg_ok && (num_groups != NG_W'(1));
    end else begin
      mul_in_v = !CEN && last_phase && !last_grp && !next_last;
    end
  end

  mulmod_pipe #(
    .P_WIDTH (P_WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (mul_a),
    .b         (mul_b),
    .n         (N_in),
    .in_valid  (mul_in_v),
    .s         (mul_s),
    .out_valid (mul_ov)
  );

  // Sequencer: config latch, phase/group counting, done and error flags
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      nxt       <= '0;
      step_q    <= '0;
      len_q     <= '0;
      ng_q      <= '0;
      phase     <= '0;
      group_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mul_ov) nxt <= mul_s;
      case (state)
        IDLE: begin
          if (start) begin
            if (!cfg_ok) begin
              err <= 1'b1;
            end else begin
              err       <= 1'b0;
              step_q    <= step_in;
              len_q     <= group_len;
              ng_q      <= num_groups;
              cur       <= seed_in;
              group_idx <= '0;
              phase     <= '0;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (!CEN) begin
            if (last_phase) begin
              if (last_grp) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                cur       <= fwd;
                group_idx <= group_idx + NG_W'(1);
                phase     <= '0;
              end
            end else begin
              phase <= phase + GL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tf_out   = cur;
  assign tf_valid = (state == RUN) && !CEN;

endmodule

// File: tb/tb_horizontal_tf_gen.sv
// Directed bench for horizontal_tf_gen: plain runs, stalls, config errors,
// single group, Goldilocks sequence, and mid-run reset.
module tb_horizontal_tf_gen;
  import horizontal_tf_pkg::*;

  localparam int unsigned PW  = 64;
  localparam int unsigned GW  = 4;
  localparam int unsigned NW  = 5;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic          start;
  logic [PW-1:0] seed;
  logic [PW-1:0] step;
  logic [PW-1:0] nmod;
  logic [GW-1:0] glen;
  logic [NW-1:0] ngrp;
  logic [PW-1:0] tf_out;
  logic          tf_valid;
  logic [NW-1:0] group_idx;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] cap_val[$];
  logic [NW-1:0] cap_idx[$];
  int            cap_done;
  int            cap_gap;
  logic          cap_busy_done;

  logic [PW-1:0] exp_small[4] = '{64'd3, 64'd6, 64'd12, 64'd7};
  logic [PW-1:0] exp_gold[16];

  horizontal_tf_gen #(
    .P_WIDTH (PW),
    .GL_W    (GW),
    .NG_W    (NW),
    .MUL_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CEN        (cen),
    .start      (start),
    .seed_in    (seed),
    .step_in    (step),
    .N_in       (nmod),
    .group_len  (glen),
    .num_groups (ngrp),
    .tf_out     (tf_out),
    .tf_valid   (tf_valid),
    .group_idx  (group_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Shift-and-add modular multiply, independent of a wide % operator
  function automatic logic [PW-1:0] mm(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                       input logic [PW-1:0] n);
    logic [PW:0] r;
    r = '0;
    for (int i = PW - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= {1'b0, n}) r = r - {1'b0, n};
      if (b[i]) begin
        r = r + {1'b0, a};
        if (r >= {1'b0, n}) r = r - {1'b0, n};
      end
    end
    return r[PW-1:0];
  endfunction

  task automatic set_cfg(input logic [PW-1:0] n, input logic [PW-1:0] s, input logic [PW-1:0] st,
                         input logic [GW-1:0] gl, input logic [NW-1:0] ng);
    nmod = n; seed = s; step = st; glen = gl; ngrp = ng;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records every valid cycle until done (or the cycle budget runs out)
  task automatic capture(input int max_cyc, input int stall_at, input int stall_len,
                         input int xs0, input int xs1);
    cap_val.delete();
    cap_idx.delete();
    cap_done      = -1;
    cap_gap       = 0;
    cap_busy_done = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      cen   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      start = (cyc == xs0) || (cyc == xs1);
      @(negedge clk);
      if (tf_valid) begin
        cap_val.push_back(tf_out);
        cap_idx.push_back(group_idx);
      end else if (busy) begin
        cap_gap++;
      end
      if (done) begin
        cap_done      = cyc;
        cap_busy_done = busy;
      end
      @(posedge clk); #1;
      if (cap_done >= 0) break;
    end
    cen   = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; cen = 1'b0; start = 1'b0;
    set_cfg(64'd17, 64'd0, 64'd0, 4'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    if (tf_out !== 64'd0) begin bad++; $display("FAIL reset_tf_out got=%0h want=0", tf_out); end
    total++;
    if (tf_valid !== 1'b0) begin bad++; $display("FAIL reset_tf_valid got=%b want=0", tf_valid); end
    total++;
    if (group_idx !== 5'd0) begin bad++; $display("FAIL reset_group_idx got=%0d want=0", group_idx); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++;
    rst_n = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    set_cfg(64'd17, 64'd3, 64'd2, 4'd4, 5'd4);
    pulse_start();
    capture(60, -1, 0, -1, -1);
    if (cap_val.size() != 16) begin bad++; $display("FAIL basic_count got=%0d want=16", cap_val.size()); end
    total++;
    for (int i = 0; i < cap_val.size() && i < 16; i++) begin
      if (cap_val[i] !== exp_small[i/4]) begin
        bad++; $display("FAIL basic_val[%0d] got=%0d want=%0d", i, cap_val[i], exp_small[i/4]);
      end
      total++;
      if (cap_idx[i] !== NW'(i/4)) begin
        bad++; $display("FAIL basic_idx[%0d] got=%0d want=%0d", i, cap_idx[i], i/4);
      end
      total++;
    end
    if (cap_done != 16) begin bad++; $display("FAIL basic_done_cycle got=%0d want=16", cap_done); end
    total++;
    if (cap_busy_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", cap_busy_done); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse_width got=%b want=0", done); end
    total++;
    if (tf_out !== 64'd7) begin bad++; $display("FAIL basic_tf_hold got=%0d want=7", tf_out); end
    total++;
  endtask

  task automatic test_stall();
    set_cfg(64'd17, 64'd3, 64'd2, 4'd4, 5'd4);
    pulse_start();
    capture(60, 5, 5, -1, -1);
    if (cap_val.size() != 16) begin bad++; $display("FAIL stall_count got=%0d want=16", cap_val.size()); end
    total++;
    for (int i = 0; i < cap_val.size() && i < 16; i++) begin
      if (cap_val[i] !== exp_small[i/4] || cap_idx[i] !== NW'(i/4)) begin
        bad++; $display("FAIL stall_val[%0d] got=%0d/%0d want=%0d/%0d", i, cap_val[i], cap_idx[i],
                        exp_small[i/4], i/4);
      end
      total++;
    end
    if (cap_gap != 5) begin bad++; $display("FAIL stall_gap got=%0d want=5", cap_gap); end
    total++;
    if (cap_done != 21) begin bad++; $display("FAIL stall_done_cycle got=%0d want=21", cap_done); end
    total++;
  endtask

  task automatic test_err();
    int highs;
    set_cfg(64'd17, 64'd3, 64'd2, 4'd2, 5'd4);
    pulse_start();
    if (err !== 1'b1) begin bad++; $display("FAIL err_short_len got=%b want=1", err); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL err_busy got=%b want=0", busy); end
    total++;
    highs = 0;
    repeat (4) begin
      @(negedge clk);
      if (tf_valid) highs++;
    end
    @(posedge clk); #1;
    if (highs != 0) begin bad++; $display("FAIL err_tf_valid got=%0d want=0", highs); end
    total++;
    // group_len equal to the multiplier latency is the tightest legal case
    glen = 4'd3;
    pulse_start();
    if (err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", err); end
    total++;
    capture(60, -1, 0, -1, -1);
    if (cap_val.size() != 12) begin bad++; $display("FAIL tight_count got=%0d want=12", cap_val.size()); end
    total++;
    for (int i = 0; i < cap_val.size() && i < 12; i++) begin
      if (cap_val[i] !== exp_small[i/3] || cap_idx[i] !== NW'(i/3)) begin
        bad++; $display("FAIL tight_val[%0d] got=%0d/%0d want=%0d/%0d", i, cap_val[i], cap_idx[i],
                        exp_small[i/3], i/3);
      end
      total++;
    end
    if (cap_done != 12) begin bad++; $display("FAIL tight_done_cycle got=%0d want=12", cap_done); end
    total++;
    set_cfg(64'd17, 64'd3, 64'd2, 4'd4, 5'd0);
    pulse_start();
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL err_zero_groups got=%b/%b want=1/0", err, busy);
    end
    total++;
  endtask

  task automatic test_single();
    set_cfg(64'd17, 64'd5, 64'd7, 4'd3, 5'd1);
    pulse_start();
    capture(30, -1, 0, -1, -1);
    if (cap_val.size() != 3) begin bad++; $display("FAIL single_count got=%0d want=3", cap_val.size()); end
    total++;
    for (int i = 0; i < cap_val.size() && i < 3; i++) begin
      if (cap_val[i] !== 64'd5 || cap_idx[i] !== NW'(0)) begin
        bad++; $display("FAIL single_val[%0d] got=%0d/%0d want=5/0", i, cap_val[i], cap_idx[i]);
      end
      total++;
    end
    if (cap_done != 3) begin bad++; $display("FAIL single_done_cycle got=%0d want=3", cap_done); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", err); end
    total++;
  endtask

  task automatic test_gold();
    exp_gold[0] = 64'd1;
    for (int k = 1; k < 16; k++) exp_gold[k] = mm(exp_gold[k-1], 64'h381d997f2d35d682, N_GOLD);
    set_cfg(N_GOLD, 64'd1, 64'h381d997f2d35d682, 4'd4, 5'd16);
    pulse_start();
    seed = 64'd5;
    capture(200, -1, 0, 10, 40);
    if (cap_val.size() != 64) begin bad++; $display("FAIL gold_count got=%0d want=64", cap_val.size()); end
    total++;
    for (int i = 0; i < cap_val.size() && i < 64; i++) begin
      if (cap_val[i] !== exp_gold[i/4] || cap_idx[i] !== NW'(i/4)) begin
        bad++; $display("FAIL gold_val[%0d] got=%0h/%0d want=%0h/%0d", i, cap_val[i], cap_idx[i],
                        exp_gold[i/4], i/4);
      end
      total++;
    end
    if (cap_done != 64) begin bad++; $display("FAIL gold_done_cycle got=%0d want=64", cap_done); end
    total++;
  endtask

  task automatic test_reset_mid();
    set_cfg(64'd17, 64'd3, 64'd2, 4'd4, 5'd4);
    pulse_start();
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    #1;
    if (tf_out !== 64'd0 || tf_valid !== 1'b0 || group_idx !== 5'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got=%0h/%b/%0d/%b want=0/0/0/0", tf_out, tf_valid, group_idx, busy);
    end
    total++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    if (done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b want=0", done); end
    total++;
    @(posedge clk); #1;
    pulse_start();
    capture(60, -1, 0, -1, -1);
    if (cap_val.size() != 16) begin bad++; $display("FAIL midrst_count got=%0d want=16", cap_val.size()); end
    total++;
    for (int i = 0; i < cap_val.size() && i < 16; i++) begin
      if (cap_val[i] !== exp_small[i/4]) begin
        bad++; $display("FAIL midrst_val[%0d] got=%0d want=%0d", i, cap_val[i], exp_small[i/4]);
      end
      total++;
    end
    if (cap_done != 16) begin bad++; $display("FAIL midrst_done_cycle got=%0d want=16", cap_done); end
    total++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_single();
    test_gold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
